// File: rtl/dump_sequencer.sv
// Streams PC, register file and data memory out over a byte-wide UART,
// one word at a time, most significant byte first.
module dump_sequencer #(
    parameter int DATA_WIDTH      = 32,
    parameter int DATA_WIDTH_UART = 8,
    parameter int NREGS           = 32,
    parameter int NMEM            = 32
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic                       i_dump,
    input  logic                       i_abort,
    input  logic [DATA_WIDTH-1:0]      i_pc,
    input  logic [DATA_WIDTH-1:0]      i_reg,
    input  logic [DATA_WIDTH-1:0]      i_mem,
    input  logic                       i_tx_done,
    output logic                       o_tx_start,
    output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
    output logic [4:0]                 o_reg_addr,
    output logic [4:0]                 o_mem_addr,
    output logic                       o_reg_send,
    output logic                       o_mem_send,
    output logic                       o_busy,
    output logic                       o_done
);

    localparam int NWORDS = 1 + NREGS + NMEM;
    localparam int WIDX_W = $clog2(NWORDS);
    localparam int NBYTES = DATA_WIDTH / DATA_WIDTH_UART;
    localparam int BCNT_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    localparam logic [WIDX_W-1:0] LAST_IDX  = WIDX_W'(NWORDS - 1);
    localparam logic [WIDX_W-1:0] REG_LAST  = WIDX_W'(NREGS);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(NBYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [WIDX_W-1:0]     r_widx;
    logic [BCNT_W-1:0]     r_bcnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx_start;
    logic                  r_busy;
    logic                  r_done;

    logic                  w_in_reg;
    logic                  w_in_mem;
    logic                  w_clear;
    logic [DATA_WIDTH-1:0] w_word;

    assign w_in_reg = (r_widx != '0) && (r_widx <= REG_LAST);
    assign w_in_mem = (r_widx > REG_LAST);
    // Abort only matters once a dump is running; reset always wins.
    assign w_clear  = !i_reset || (i_abort && (r_state != S_IDLE));

    always_comb begin
        w_word = i_mem;
        if (r_widx == '0) begin
            w_word = i_pc;
        end else if (w_in_reg) begin
            w_word = i_reg;
        end
    end

    always_comb begin
        o_reg_addr = '0;
        o_mem_addr = '0;
        o_reg_send = 1'b0;
        o_mem_send = 1'b0;
        if (r_busy && w_in_reg) begin
            o_reg_addr = 5'(r_widx - WIDX_W'(1));
            o_reg_send = 1'b1;
        end else if (r_busy && w_in_mem) begin
            o_mem_addr = 5'(r_widx - WIDX_W'(NREGS + 1));
            o_mem_send = 1'b1;
        end
    end

    // Entering LOAD one cycle after r_widx changes gives async-read sources a full cycle.
    always_ff @(posedge i_clock) begin
        if (w_clear) begin
            r_state    <= S_IDLE;
            r_widx     <= '0;
            r_bcnt     <= '0;
            r_shift    <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_tx_start <= 1'b0;
                    r_done     <= 1'b0;
                    if (i_dump) begin
                        r_widx  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_shift    <= w_word;
                    r_bcnt     <= '0;
                    r_tx_start <= 1'b1;
                    r_state    <= S_SEND;
                end
                S_SEND: begin
                    r_tx_start <= 1'b0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_tx_done) begin
                        if (r_bcnt == BCNT_LAST) begin
                            r_state <= S_NEXT;
                        end else begin
                            r_shift    <= r_shift << DATA_WIDTH_UART;
                            r_bcnt     <= r_bcnt + BCNT_W'(1);
                            r_tx_start <= 1'b1;
                            r_state    <= S_SEND;
                        end
                    end
                end
                S_NEXT: begin
                    if (r_widx == LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_widx  <= r_widx + WIDX_W'(1);
                        r_state <= S_LOAD;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_shift <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_tx_start = r_tx_start;
    assign o_tx_byte  = r_shift[DATA_WIDTH-1 -: DATA_WIDTH_UART];
    assign o_busy     = r_busy;
    assign o_done     = r_done;

endmodule

// File: tb/tb_dump_sequencer.sv
// Directed bench for dump_sequencer: full dump, abort, reset mid-dump,
// held i_dump with back-to-back restart, abort/tx_done collision.
module tb_dump_sequencer;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_dump;
    logic        i_abort;
    logic [31:0] i_pc;
    logic [31:0] i_reg;
    logic [31:0] i_mem;
    logic        i_tx_done;
    logic        o_tx_start;
    logic [7:0]  o_tx_byte;
    logic [4:0]  o_reg_addr;
    logic [4:0]  o_mem_addr;
    logic        o_reg_send;
    logic        o_mem_send;
    logic        o_busy;
    logic        o_done;

    int n_checks = 0;
    int n_err    = 0;

    logic       auto_en     = 1'b0;
    logic       done_auto   = 1'b0;
    logic       manual_done = 1'b0;
    int         cnt         = 0;
    int         nstart      = 0;
    int         ndone       = 0;
    logic [7:0] bytes [0:1023];
    logic [6:0] snap_reg    = '0;
    logic [6:0] snap_mem    = '0;

    always #5 clk = ~clk;

    assign i_reg     = 32'(o_reg_addr);
    assign i_mem     = 32'hA000_0000 + 32'(o_mem_addr);
    assign i_tx_done = done_auto | manual_done;

    dump_sequencer #(
        .DATA_WIDTH     (32),
        .DATA_WIDTH_UART(8),
        .NREGS          (32),
        .NMEM           (32)
    ) dut (
        .i_clock   (clk),
        .i_reset   (i_reset),
        .i_dump    (i_dump),
        .i_abort   (i_abort),
        .i_pc      (i_pc),
        .i_reg     (i_reg),
        .i_mem     (i_mem),
        .i_tx_done (i_tx_done),
        .o_tx_start(o_tx_start),
        .o_tx_byte (o_tx_byte),
        .o_reg_addr(o_reg_addr),
        .o_mem_addr(o_mem_addr),
        .o_reg_send(o_reg_send),
        .o_mem_send(o_mem_send),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    // UART model: one-cycle done pulse 10 cycles after each start.
    always @(negedge clk) begin
        done_auto = 1'b0;
        if (!auto_en) begin
            cnt = 0;
        end else begin
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) done_auto = 1'b1;
            end
            if (o_tx_start) cnt = 10;
        end
    end

    always @(negedge clk) begin
        if (o_tx_start) begin
            if (nstart == 24)  snap_reg = {o_reg_send, o_mem_send, o_reg_addr};
            if (nstart == 256) snap_mem = {o_mem_send, o_reg_send, o_mem_addr};
            if (nstart < 1024) bytes[nstart] = o_tx_byte;
            nstart++;
        end
        if (o_done) ndone++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_tx_start"}, o_tx_start, 1'b0);
        check({tag, "_tx_byte"},  o_tx_byte,  8'h00);
        check({tag, "_reg_addr"}, o_reg_addr, 5'd0);
        check({tag, "_mem_addr"}, o_mem_addr, 5'd0);
        check({tag, "_reg_send"}, o_reg_send, 1'b0);
        check({tag, "_mem_send"}, o_mem_send, 1'b0);
        check({tag, "_busy"},     o_busy,     1'b0);
        check({tag, "_done"},     o_done,     1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_starts(input int n, input int budget);
        for (int c = 0; c < budget && nstart < n; c++) step();
        check("start_budget", (nstart >= n), 1'b1);
    endtask

    task automatic wait_done(input int budget);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < budget && !seen; c++) begin
            step();
            if (o_done) seen = 1'b1;
        end
        check("done_budget", seen, 1'b1);
    endtask

    initial begin
        int base;
        int bd;
        i_reset = 1'b0;
        i_dump  = 1'b0;
        i_abort = 1'b0;
        i_pc    = 32'h0000_0040;

        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        i_reset = 1'b1;
        step();

        // Full dump
        base = nstart;
        bd   = ndone;
        auto_en = 1'b1;
        i_dump  = 1'b1;
        step();
        check("busy_after_dump", o_busy, 1'b1);
        check("load_no_start", o_tx_start, 1'b0);
        i_dump = 1'b0;
        step();
        check("first_start", o_tx_start, 1'b1);
        check("first_byte", o_tx_byte, 8'h00);
        check("pc_no_reg_send", o_reg_send, 1'b0);
        wait_done(4000);
        check("busy_at_done", o_busy, 1'b0);
        repeat (3) step();
        check("full_starts", nstart - base, 260);
        check("full_dones", ndone - bd, 1);
        check("pc_bytes", {bytes[0], bytes[1], bytes[2], bytes[3]}, 32'h0000_0040);
        check("reg0_bytes", {bytes[4], bytes[5], bytes[6], bytes[7]}, 32'h0000_0000);
        check("reg5_lsb", bytes[27], 8'h05);
        check("mem0_bytes", {bytes[132], bytes[133], bytes[134], bytes[135]}, 32'hA000_0000);
        check("last_bytes", {bytes[256], bytes[257], bytes[258], bytes[259]}, 32'hA000_001F);
        check("reg5_addr_snap", snap_reg, 7'h45);
        check("mem31_addr_snap", snap_mem, 7'h5F);

        // Abort after 10 bytes, then restart
        base = nstart;
        bd   = ndone;
        i_dump = 1'b1;
        step();
        i_dump = 1'b0;
        wait_starts(base + 10, 500);
        i_abort = 1'b1;
        auto_en = 1'b0;
        step();
        check_idle_outputs("abort");
        i_abort = 1'b0;
        repeat (30) step();
        check("abort_starts", nstart - base, 10);
        check("abort_no_done", ndone - bd, 0);
        base = nstart;
        auto_en = 1'b1;
        i_dump  = 1'b1;
        step();
        i_dump = 1'b0;
        wait_starts(base + 4, 200);
        check("restart_pc_bytes",
              {bytes[base], bytes[base+1], bytes[base+2], bytes[base+3]}, 32'h0000_0040);
        i_abort = 1'b1;
        auto_en = 1'b0;
        step();
        i_abort = 1'b0;
        step();

        // Abort and tx_done in the same cycle
        base = nstart;
        i_dump = 1'b1;
        step();
        i_dump = 1'b0;
        wait_starts(base + 1, 20);
        i_abort     = 1'b1;
        manual_done = 1'b1;
        step();
        check("collide_busy", o_busy, 1'b0);
        check("collide_start", o_tx_start, 1'b0);
        i_abort     = 1'b0;
        manual_done = 1'b0;
        repeat (5) step();
        check("collide_starts", nstart - base, 1);

        // Reset while waiting on byte 7
        base = nstart;
        auto_en = 1'b1;
        i_dump  = 1'b1;
        step();
        i_dump = 1'b0;
        wait_starts(base + 8, 500);
        auto_en = 1'b0;
        i_reset = 1'b0;
        step();
        check_idle_outputs("midreset");
        i_reset     = 1'b1;
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        repeat (5) step();
        check("midreset_starts", nstart - base, 8);
        check("midreset_busy", o_busy, 1'b0);

        // Spurious tx_done in IDLE, then i_dump held through a whole dump
        base = nstart;
        bd   = ndone;
        manual_done = 1'b1;
        step();
        manual_done = 1'b0;
        repeat (3) step();
        check("spurious_busy", o_busy, 1'b0);
        check("spurious_starts", nstart - base, 0);
        auto_en = 1'b1;
        i_dump  = 1'b1;
        wait_done(4000);
        check("held_starts", nstart - base, 260);
        step();
        check("held_idle_gap_busy", o_busy, 1'b0);
        check("held_idle_gap_done", o_done, 1'b0);
        step();
        check("held_restart_busy", o_busy, 1'b1);
        wait_starts(base + 264, 200);
        check("held_dones", ndone - bd, 1);
        check("held_restart_pc",
              {bytes[base+260], bytes[base+261], bytes[base+262], bytes[base+263]},
              32'h0000_0040);
        i_dump  = 1'b0;
        i_abort = 1'b1;
        auto_en = 1'b0;
        step();
        i_abort = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/dump_sequencer.md
DUMP_SEQUENCER -- requirements
Module: DUMP_SEQUENCER

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: width of the PC, register and memory words.
REQ-002 SHALL have parameter DATA_WIDTH_UART, default 8: UART byte width.
REQ-003 SHALL have parameter NREGS, default 32: number of registers dumped.
REQ-004 SHALL have parameter NMEM, default 32: number of data-memory words dumped.
REQ-005 SHALL have port i_clock  in  1: the only clock; all state updates on its rising edge.
REQ-006 SHALL have port i_reset  in  1: reset, synchronous, active-low.
REQ-007 SHALL have port i_dump  in  1: start-dump request, level sampled in IDLE.
REQ-008 SHALL have port i_abort  in  1: abort the current dump.
REQ-009 SHALL have port i_pc  in  DATA_WIDTH: current PC.
REQ-010 SHALL have port i_reg  in  DATA_WIDTH: register-file read data for o_reg_addr.
REQ-011 SHALL have port i_mem  in  DATA_WIDTH: data-memory read data for o_mem_addr.
REQ-012 SHALL have port i_tx_done  in  1: one-cycle pulse from the UART TX at the end of each byte.
REQ-013 SHALL have port o_tx_start  out  1: one-cycle pulse that launches a byte.
REQ-014 SHALL have port o_tx_byte  out  DATA_WIDTH_UART: byte to transmit.
REQ-015 SHALL have port o_reg_addr  out  5: register debug read index.
REQ-016 SHALL have port o_mem_addr  out  5: memory debug read index.
REQ-017 SHALL have port o_reg_send  out  1: register debug read enable.
REQ-018 SHALL have port o_mem_send  out  1: memory debug read enable.
REQ-019 SHALL have port o_busy  out  1: dump in progress.
REQ-020 SHALL have port o_done  out  1: one-cycle pulse when the dump completes.

Function
REQ-021 SHALL implement the states IDLE, LOAD, SEND, WAIT, NEXT and DONE.
REQ-022 SHALL hold a word index widx in the range 0..1+NREGS+NMEM-1 (0..64 at the defaults).
- widx=0 selects the PC.
- widx 1..NREGS selects register widx-1.
- The remaining widx values select memory word widx-1-NREGS.
REQ-023 SHALL drive the read ports combinationally from widx while o_busy=1.
- o_reg_addr=widx-1 and o_reg_send=1 while widx is in the register range.
- o_mem_addr=widx-1-NREGS and o_mem_send=1 while widx is in the memory range.
- Otherwise both addresses are 0 and both enables are 0.
REQ-024 IDLE: when i_dump=1, SHALL set widx=0 and go to LOAD; o_busy=1 from that next cycle.
REQ-025 LOAD: SHALL capture the selected word (i_pc, i_reg or i_mem) into a 32-bit shift register, clear the byte counter and go to SEND.
- The capture happens at least one cycle after widx changes, so asynchronous-read sources are valid.
REQ-026 SEND: SHALL assert o_tx_start for exactly one cycle with o_tx_byte = shift[31:24], then go to WAIT.
REQ-027 WAIT: SHALL hold o_tx_byte stable until i_tx_done arrives.
- On i_tx_done with byte counter = 3: go to NEXT.
- On i_tx_done otherwise: shift left by 8, increment the byte counter, go to SEND.
REQ-028 Byte order SHALL be MSB first; each word is 4 bytes; a full dump at the defaults is 65 words = 260 bytes.
REQ-029 NEXT: if widx is the last index, SHALL go to DONE; otherwise increment widx and go to LOAD.
REQ-030 DONE: SHALL assert o_done for one cycle, deassert o_busy and return to IDLE.
REQ-031 i_dump outside IDLE SHALL be ignored; i_tx_done outside WAIT SHALL be ignored.
REQ-032 i_abort=1 in any non-IDLE state SHALL return to IDLE on the next edge.
- o_busy=0 and all outputs take their reset values.
- No o_done pulse, and no further o_tx_start.
REQ-033 If i_abort and i_tx_done arrive in the same cycle, SHALL give abort priority.
REQ-034 Back-to-back dumps SHALL be possible: i_dump=1 on the cycle after DONE starts a new dump.

Reset
REQ-035 i_reset=0 on a rising edge SHALL force IDLE with widx=0, byte counter=0 and shift=0.
- Outputs: o_tx_start=0, o_tx_byte=0, o_reg_addr=0, o_mem_addr=0, o_reg_send=0, o_mem_send=0, o_busy=0, o_done=0.
REQ-036 Reset mid-dump SHALL abort without a residual o_tx_start; i_reset SHALL take priority over all other inputs.

Verification
REQ-037 Full dump, UART model answering i_tx_done 10 cycles after each o_tx_start: i_pc=0x00000040, reg k=k, mem k=0xA000_0000+k -> exactly 260 o_tx_start pulses, then one o_done pulse.
- Bytes 0..3 = 00 00 00 40.
- Bytes 4..7 = 00 00 00 00 (reg 0).
- Bytes 132..135 = A0 00 00 00 (mem 0).
- Last 4 bytes = A0 00 00 1F.
REQ-038 Address check: during the word for register 5, o_reg_addr=5, o_reg_send=1, o_mem_send=0; during memory word 31, o_mem_addr=31, o_mem_send=1.
REQ-039 Abort after 10 bytes -> o_busy=0 on the next cycle, no o_done, no further o_tx_start; a subsequent i_dump restarts from the PC bytes.
REQ-040 Reset (i_reset=0) asserted in WAIT during byte 7 -> all outputs 0 on the next cycle; a spurious i_tx_done after the reset produces no o_tx_start.
REQ-041 i_dump held high during an entire dump, plus a spurious i_tx_done in IDLE -> no restart while busy; a second dump starts on the cycle after o_done; the spurious pulse has no effect.
REQ-042 i_abort and i_tx_done asserted in the same cycle -> state IDLE, no extra o_tx_start.
